// File: rtl/lfsr_pkg.sv
// Shared LFSR constants: maximal-length tap masks for common widths and the
// single-step Fibonacci shift function used by lfsr_core.
package lfsr_pkg;

  localparam int LFSR_MAX_W = 64;

  localparam logic [7:0]  TAPS_8  = 8'hB8;
  localparam logic [15:0] TAPS_16 = 16'hB400;
  localparam logic [23:0] TAPS_24 = 24'hE1_0000;
  localparam logic [29:0] TAPS_30 = 30'h2000_0029;
  localparam logic [31:0] TAPS_32 = 32'h8020_0003;

  // Callers zero-extend state/taps to LFSR_MAX_W and keep the low WIDTH bits.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_step(
    input logic [LFSR_MAX_W-1:0] state,
    input logic [LFSR_MAX_W-1:0] taps
  );
    return {state[LFSR_MAX_W-2:0], ^(state & taps)};
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// LFSR state register with seed load, step enable and zero-state recovery.
// One step per enabled cycle; seed_load wins over en; lockup pulses the cycle after a zero is replaced.
module lfsr_core import lfsr_pkg::*; #(
  parameter int               WIDTH = 30,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS_30),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(13)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] state_nxt,
  output logic             lockup
);

  logic [WIDTH-1:0]      state_q, state_d;
  logic                  lockup_q, lockup_d;
  logic [LFSR_MAX_W-1:0] step_wide;
  logic [WIDTH-1:0]      state_step;
  logic                  step_hi_unused;

  assign step_wide      = lfsr_step(LFSR_MAX_W'(state_q), LFSR_MAX_W'(TAPS));
  assign state_step     = step_wide[WIDTH-1:0];
  assign step_hi_unused = ^step_wide[LFSR_MAX_W-1:WIDTH];

  always_comb begin
    state_d  = state_q;
    lockup_d = 1'b0;
    if (seed_load) begin
      if (seed_in == '0) begin
        state_d  = SEED;
        lockup_d = 1'b1;
      end else begin
        state_d  = seed_in;
      end
    end else if (en) begin
      // A zero state would stick forever; only reachable with degenerate taps.
      if (state_step == '0) begin
        state_d  = SEED;
        lockup_d = 1'b1;
      end else begin
        state_d  = state_step;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SEED;
      lockup_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      lockup_q <= lockup_d;
    end
  end

  assign state_nxt = state_d;
  assign lockup    = lockup_q;

endmodule

// File: rtl/lfsr_rng.sv
// Decimated LFSR random source: captures the post-step state every SAMPLE_PERIOD steps.
// rand_valid rises 1 cycle after the capturing step; unconsumed samples are overwritten (freshest wins) and flag overrun.
module lfsr_rng import lfsr_pkg::*; #(
  parameter int               WIDTH         = 30,
  parameter logic [WIDTH-1:0] TAPS          = WIDTH'(TAPS_30),
  parameter logic [WIDTH-1:0] SEED          = WIDTH'(13),
  parameter int               SAMPLE_PERIOD = 31
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             rand_ready,
  output logic             rand_valid,
  output logic [WIDTH-1:0] rand_out,
  output logic             overrun,
  output logic             lockup
);

  localparam int CNT_W = $clog2(SAMPLE_PERIOD + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_PERIOD - 1);

  logic [WIDTH-1:0] state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rand_out_q, rand_out_d;
  logic             rand_valid_q, rand_valid_d;
  logic             overrun_q, overrun_d;
  logic             step, capture, consume;

  lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .seed_load (seed_load),
    .seed_in   (seed_in),
    .state_nxt (state_nxt),
    .lockup    (lockup)
  );

  assign step    = en && !seed_load;
  assign capture = step && (cnt_q == CNT_LAST);
  assign consume = rand_valid_q && rand_ready;

  always_comb begin
    cnt_d        = cnt_q;
    rand_out_d   = rand_out_q;
    rand_valid_d = rand_valid_q;
    overrun_d    = overrun_q;

    if (seed_load) begin
      cnt_d = '0;
    end else if (step) begin
      cnt_d = capture ? '0 : cnt_q + CNT_W'(1);
    end

    if (capture) begin
      rand_out_d   = state_nxt;
      rand_valid_d = 1'b1;
    end else if (consume) begin
      rand_valid_d = 1'b0;
    end

    // seed_load and capture are mutually exclusive, so the clear never races the set.
    if (seed_load) begin
      overrun_d = 1'b0;
    end else if (capture && rand_valid_q && !rand_ready) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      rand_out_q   <= '0;
      rand_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      rand_out_q   <= rand_out_d;
      rand_valid_q <= rand_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rand_out   = rand_out_q;
  assign rand_valid = rand_valid_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_lfsr_rng.sv
// Bench for lfsr_rng: directed vector table, random run against a reference model,
// an 8-bit maximal-length sweep, and a degenerate-tap instance for step-path lockup.
module tb_lfsr_rng;
  import lfsr_pkg::*;

  localparam int W = 30;
  localparam int P = 4;
  localparam logic [W-1:0] SEED_V = 30'h0000_000D;

  logic         clk, rst_n, en, seed_load, rand_ready;
  logic [W-1:0] seed_in, rand_out;
  logic         rand_valid, overrun, lockup;

  logic         en_aux;
  logic [7:0]   r8;
  logic         v8, o8, l8;
  logic [3:0]   r4;
  logic         v4, o4, l4;

  int n_chk = 0;
  int n_err = 0;

  lfsr_rng #(.WIDTH(W), .TAPS(TAPS_30), .SEED(SEED_V), .SAMPLE_PERIOD(P)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .seed_load(seed_load), .seed_in(seed_in),
    .rand_ready(rand_ready), .rand_valid(rand_valid), .rand_out(rand_out),
    .overrun(overrun), .lockup(lockup)
  );

  lfsr_rng #(.WIDTH(8), .TAPS(TAPS_8), .SEED(8'h01), .SAMPLE_PERIOD(1)) u8 (
    .clk(clk), .rst_n(rst_n), .en(en_aux), .seed_load(1'b0), .seed_in(8'h00),
    .rand_ready(1'b1), .rand_valid(v8), .rand_out(r8), .overrun(o8), .lockup(l8)
  );

  lfsr_rng #(.WIDTH(4), .TAPS(4'h0), .SEED(4'h1), .SAMPLE_PERIOD(1)) u4 (
    .clk(clk), .rst_n(rst_n), .en(en_aux), .seed_load(1'b0), .seed_in(4'h0),
    .rand_ready(1'b1), .rand_valid(v4), .rand_out(r4), .overrun(o4), .lockup(l4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic ev, input logic [W-1:0] eo,
                          input logic eovr, input logic el);
    chk({tag, "/valid"},   32'(rand_valid), 32'(ev));
    chk({tag, "/out"},     32'(rand_out),   32'(eo));
    chk({tag, "/overrun"}, 32'(overrun),    32'(eovr));
    chk({tag, "/lockup"},  32'(lockup),     32'(el));
  endtask

  typedef struct {
    logic         en;
    logic         sl;
    logic [W-1:0] seed;
    logic         rdy;
    logic         ev;
    logic [W-1:0] eo;
    logic         eovr;
    logic         el;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic a_en, input logic a_sl, input logic [W-1:0] a_seed,
                              input logic a_rdy, input logic a_ev, input logic [W-1:0] a_eo,
                              input logic a_eovr, input logic a_el);
    vec_t v;
    v.en = a_en; v.sl = a_sl; v.seed = a_seed; v.rdy = a_rdy;
    v.ev = a_ev; v.eo = a_eo; v.eovr = a_eovr; v.el = a_el;
    vecs.push_back(v);
  endfunction

  // Reference model: state is a number, feedback is the parity of tapped bits,
  // and a sample is taken whenever the steps since the last load/reset reach a multiple of P.
  logic [W-1:0] m_state, m_out;
  logic         m_valid, m_ovr, m_lock;
  int           m_steps;

  function automatic logic [W-1:0] ref_step(input logic [W-1:0] s);
    int ones;
    ones = $countones(s & TAPS_30);
    return (s << 1) | W'(ones & 1);
  endfunction

  task automatic model_reset();
    m_state = SEED_V; m_out = '0; m_valid = 1'b0; m_ovr = 1'b0; m_lock = 1'b0; m_steps = 0;
  endtask

  task automatic model_cycle(input logic i_en, input logic i_sl, input logic [W-1:0] i_seed,
                             input logic i_rdy);
    logic [W-1:0] nxt;
    logic         consumed;
    consumed = m_valid && i_rdy;
    m_lock   = 1'b0;
    if (i_sl) begin
      m_lock  = (i_seed == '0);
      m_state = m_lock ? SEED_V : i_seed;
      m_steps = 0;
      m_ovr   = 1'b0;
      if (consumed) m_valid = 1'b0;
    end else if (i_en) begin
      nxt = ref_step(m_state);
      if (nxt == '0) begin
        nxt    = SEED_V;
        m_lock = 1'b1;
      end
      m_state = nxt;
      m_steps++;
      if (m_steps % P == 0) begin
        if (m_valid && !i_rdy) m_ovr = 1'b1;
        m_out   = nxt;
        m_valid = 1'b1;
      end else if (consumed) begin
        m_valid = 1'b0;
      end
    end else if (consumed) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  bit           seen[256];
  logic [3:0]   exp4[5];

  initial begin
    rst_n = 1'b0; en = 1'b0; seed_load = 1'b0; seed_in = '0; rand_ready = 1'b0; en_aux = 1'b0;

    #12;
    chk_outs("reset", 1'b0, '0, 1'b0, 1'b0);
    chk("reset/u8_out", 32'(r8), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table: stepping, overwrite/overrun, seed clear, consume+capture, zero seed, load priority, hold.
    for (int k = 0; k < 3; k++) add(1, 0, '0, 0, 0, '0, 0, 0);
    add(1, 0, '0, 0, 1, 30'hD4, 0, 0);
    for (int k = 0; k < 3; k++) add(1, 0, '0, 0, 1, 30'hD4, 0, 0);
    add(1, 0, '0, 0, 1, 30'hD41, 1, 0);
    add(0, 1, 30'hD, 0, 1, 30'hD41, 0, 0);
    for (int k = 0; k < 3; k++) add(1, 0, '0, 0, 1, 30'hD41, 0, 0);
    add(1, 0, '0, 1, 1, 30'hD4, 0, 0);
    add(0, 0, '0, 1, 0, 30'hD4, 0, 0);
    add(0, 1, '0, 0, 0, 30'hD4, 0, 1);
    add(1, 1, 30'h1, 0, 0, 30'hD4, 0, 0);
    for (int k = 0; k < 3; k++) add(1, 0, '0, 0, 0, 30'hD4, 0, 0);
    add(1, 0, '0, 0, 1, 30'h1E, 0, 0);
    add(0, 0, '0, 0, 1, 30'h1E, 0, 0);
    add(0, 0, '0, 0, 1, 30'h1E, 0, 0);
    add(0, 0, '0, 1, 0, 30'h1E, 0, 0);

    foreach (vecs[i]) begin
      en = vecs[i].en; seed_load = vecs[i].sl; seed_in = vecs[i].seed; rand_ready = vecs[i].rdy;
      @(negedge clk);
      chk_outs($sformatf("vec%0d", i), vecs[i].ev, vecs[i].eo, vecs[i].eovr, vecs[i].el);
    end

    // Random run against the model, with an asynchronous reset midway.
    en = 1'b0; seed_load = 1'b0; rand_ready = 1'b0;
    do_reset();
    model_reset();
    for (int c = 0; c < 200; c++) begin
      if (c == 100) begin
        #2 rst_n = 1'b0;
        #1 chk_outs("async_reset", 1'b0, '0, 1'b0, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
      end
      en         = 1'($urandom % 2);
      seed_load  = ($urandom % 16) == 0;
      seed_in    = (($urandom % 4) == 0) ? '0 : W'($urandom);
      rand_ready = ($urandom % 3) == 0;
      model_cycle(en, seed_load, seed_in, rand_ready);
      @(negedge clk);
      chk_outs($sformatf("rand%0d", c), m_valid, m_out, m_ovr, m_lock);
    end

    // 8-bit maximal-length sweep plus degenerate-tap lockup on the step path.
    en = 1'b0; seed_load = 1'b0; rand_ready = 1'b0;
    do_reset();
    foreach (seen[i]) seen[i] = 1'b0;
    seen[0] = 1'b1;
    exp4[0] = 4'h2; exp4[1] = 4'h4; exp4[2] = 4'h8; exp4[3] = 4'h1; exp4[4] = 4'h2;
    for (int s = 1; s <= 255; s++) begin
      en_aux = 1'b1;
      @(negedge clk);
      chk($sformatf("u8_unique%0d", s), 32'(seen[r8]), 32'h0);
      seen[r8] = 1'b1;
      if (s <= 5) begin
        chk($sformatf("u4_out%0d", s),  32'(r4), 32'(exp4[s-1]));
        chk($sformatf("u4_lock%0d", s), 32'(l4), 32'(s == 4));
      end
    end
    en_aux = 1'b0;
    chk("u8_return", 32'(r8), 32'h1);
    chk("u8_valid",  32'(v8), 32'h1);
    chk("u8_overrun", 32'(o8), 32'h0);
    chk("u8_lockup", 32'(l8), 32'h0);
    chk("u4_valid", 32'(v4), 32'h1);
    chk("u4_overrun", 32'(o4), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/lfsr_rng.md
Name: lfsr_rng

Overview:
Parametrised Fibonacci LFSR random-number source with a programmable tap mask, runtime seed load, step enable, and zero-state lockup recovery. It advances one step per enabled cycle. Every SAMPLE_PERIOD steps it captures a fresh word into an output register and presents it on a valid/ready handshake. It feeds game/timing logic that needs decorrelated random words rather than consecutive, highly correlated shift states.

Parameters:
WIDTH, 30, LFSR and output word width (≥3)
TAPS, 30'h2000_0029, feedback mask; bit i set → state[i] XORed into feedback
SEED, 30'h0000_000D, reset/recovery state; must be nonzero
SAMPLE_PERIOD, 31, LFSR steps between captured samples (≥1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  advance LFSR one step this cycle
seed_load  in  1  load seed_in this cycle (priority over en)
seed_in  in  WIDTH  seed value
rand_ready  in  1  consumer accepts rand_out this cycle
rand_valid  out  1  rand_out holds an unconsumed sample
rand_out  out  WIDTH  captured random word
overrun  out  1  sticky: a sample was overwritten before it was consumed
lockup  out  1  one-cycle pulse: zero state detected and replaced by SEED

Behaviour:
- Reset (async assert, sync release): state=SEED, cnt=0, rand_out=0, rand_valid=0, overrun=0, lockup=0.
- Step: fb = ^(state & TAPS); next = {state[WIDTH-2:0], fb}.
- Counter cnt has width $clog2(SAMPLE_PERIOD+1) and range 0..SAMPLE_PERIOD-1. It advances only on step cycles.
- Priority each cycle: seed_load > en > hold.
- seed_load=1:
  - state=seed_in, or SEED if seed_in==0; in the zero case lockup pulses next cycle.
  - cnt=0, overrun cleared.
  - rand_valid/rand_out are unaffected, except that rand_ready is still honoured.
- en=1, seed_load=0:
  - state=next.
  - If next==0 (only possible with a degenerate TAPS), state=SEED and lockup pulses.
  - If cnt==SAMPLE_PERIOD-1: cnt=0 and a capture occurs. Otherwise cnt++.
- Capture:
  - rand_out = the post-step state, i.e. the value state holds after this edge.
  - rand_valid=1 on the following cycle, so capture latency is 1 cycle after the final step edge.
- Handshake:
  - rand_valid && rand_ready at an edge consumes the sample: rand_valid=0 unless a capture occurs on the same edge.
  - Simultaneous consume + capture: new word loaded, rand_valid stays 1, no overrun.
  - Capture while rand_valid && !rand_ready: rand_out is overwritten (freshest wins), rand_valid stays 1, overrun=1 (sticky).
  - rand_out is stable while rand_valid && !rand_ready, except when a capture overwrites it.
- Overrun clears only on reset or seed_load.
- en=0: state and cnt hold; the handshake still operates.
- SAMPLE_PERIOD=1: capture on every step.
- Reset mid-operation discards any pending sample; the state returns to SEED.

Decomposition:
- Package lfsr_pkg:
  - Maximal-length tap-mask constants for widths 8/16/24/30/32 (e.g. TAPS_30 = 30'h2000_0029).
  - Function lfsr_step(state, taps).
- Sub-module lfsr_core holds the state register plus step, seed and lockup logic.
- The top level adds the period counter, capture register and handshake.

Test Plan:
1. Reset, en=1, SAMPLE_PERIOD=4, rand_ready=0 → state steps 0xD→0x1A→0x35→0x6A→0xD4. rand_valid rises the cycle after the 4th edge, with rand_out=0xD4 and overrun=0.
2. Continue with rand_ready=0 for 4 more steps → rand_out is overwritten with the 8th-step state, overrun=1, and rand_valid stays 1. Then pulse seed_load → overrun=0.
3. With rand_valid=1, assert rand_ready on the exact edge of the next capture → rand_out shows the new word, rand_valid stays 1, overrun stays 0. Next cycle rand_ready=1 with no capture → rand_valid=0.
4. seed_load=1, seed_in=0 → state=0xD, one-cycle lockup pulse, cnt=0. Then seed_load=1 and en=1 with seed_in=0x1 → state=0x1 (load wins over step).
5. Toggle en pseudo-randomly across 200 cycles, with a reference model in the bench → captures occur exactly every 4th enabled step and rand_out matches the model. Assert rst_n low mid-run → outputs clear asynchronously and state=0xD.
6. Instantiate WIDTH=8, TAPS=8'hB8 via lfsr_pkg, and run 255 steps from SEED=1 → every nonzero state is visited once, and the state returns to 1 on step 255.
